// File: rtl/memcopy_engine.sv
// rtl/memcopy_engine.sv - ROM->RAM block-copy controller, one word per clock (optional checksum: MEMCOPY_CHECKSUM_EN)
module memcopy_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] din,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] dout,
  output logic              we,
  output logic              busy,
  output logic              done
`ifdef MEMCOPY_CHECKSUM_EN
  ,
  output logic [15:0]       csum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] addr_in_q;
  logic [ADDR_W-1:0] addr_out_q;
  logic [DATA_W-1:0] dout_q;
  logic [RD_LAT-1:0] vpipe;
  logic [RD_LAT-1:0] vpipe_nxt;
  logic [ADDR_W-1:0] wr_addr;
  logic              accept;
  logic              issue;
  logic              last_rd;
  logic              tail;

  // A start only counts when no copy is in flight
  assign accept  = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_rd = (rd_cnt == (len_q - {{ADDR_W{1'b0}}, 1'b1}));
  assign tail    = vpipe[RD_LAT-1];
  assign wr_addr = dst_q + wr_cnt;

  // Valid pipe mirrors the ROM latency: a read issued now lands RD_LAT cycles later
  generate
    if (RD_LAT == 1) begin : g_pipe1
      assign vpipe_nxt = issue;
    end else begin : g_pipen
      assign vpipe_nxt = {vpipe[RD_LAT-2:0], issue};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; len==0 goes straight to DONE without touching memory
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_nxt = (len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (last_rd) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (vpipe_nxt == '0) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: reads are issued for every RUN cycle
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    issue = 1'b0;
    case (state)
      S_RUN:   begin busy = 1'b1; issue = 1'b1; end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Write port follows the pipe tail directly and holds its last value otherwise
  always_comb begin
    we       = tail;
    addr_out = tail ? wr_addr : addr_out_q;
    dout     = tail ? din     : dout_q;
  end

  assign addr_in = addr_in_q;

  // Read side: latch the job on accept, then step the ROM address once per RUN cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q     <= '0;
      dst_q     <= '0;
      rd_cnt    <= '0;
      addr_in_q <= '0;
      vpipe     <= '0;
    end else begin
      vpipe <= vpipe_nxt;
      if (accept) begin
        len_q     <= len;
        dst_q     <= dst_base;
        rd_cnt    <= '0;
        addr_in_q <= src_base;
      end else if (issue) begin
        rd_cnt <= rd_cnt + 1'b1;
        // Address stays on the last word once the final read is out
        if (!last_rd) addr_in_q <= addr_in_q + 1'b1;
      end
    end
  end

  // Write side: remember the last written word/address and advance the write count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt     <= '0;
      addr_out_q <= '0;
      dout_q     <= '0;
    end else if (accept) begin
      wr_cnt <= '0;
    end else if (tail) begin
      wr_cnt     <= wr_cnt + 1'b1;
      addr_out_q <= wr_addr;
      dout_q     <= din;
    end
  end

`ifdef MEMCOPY_CHECKSUM_EN
  // Running 16-bit sum of every word written during the current job
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      csum <= '0;
    else if (accept) csum <= '0;
    else if (tail)   csum <= csum + 16'(din);
  end
`endif

endmodule

// File: tb/tb_memcopy_engine.sv
// tb/tb_memcopy_engine.sv - directed table-driven bench for memcopy_engine
module tb_memcopy_engine;
  localparam int AW = 10;
  localparam int DW = 8;

  typedef struct {
    int len;
    int src;
    int dst;
    int writes;
    int first_we;
    int last_we;
    int busy_first;
    int busy_last;
    int done_cyc;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, start3;
  logic [AW:0]   len, len3;
  logic [AW-1:0] src_base, dst_base, src3, dst3;
  logic [AW-1:0] addr_in, addr_out, addr_in3, addr_out3;
  logic [DW-1:0] din, dout, din3, dout3;
  logic          we, busy, done, we3, busy3, done3;
`ifdef MEMCOPY_CHECKSUM_EN
  logic [15:0]   csum, csum3;
`endif

  memcopy_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .src_base(src_base), .dst_base(dst_base), .addr_in(addr_in), .din(din),
    .addr_out(addr_out), .dout(dout), .we(we), .busy(busy), .done(done)
`ifdef MEMCOPY_CHECKSUM_EN
    , .csum(csum)
`endif
  );

  memcopy_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .len(len3),
    .src_base(src3), .dst_base(dst3), .addr_in(addr_in3), .din(din3),
    .addr_out(addr_out3), .dout(dout3), .we(we3), .busy(busy3), .done(done3)
`ifdef MEMCOPY_CHECKSUM_EN
    , .csum(csum3)
`endif
  );

  always #5 clk = ~clk;

  // ROM models: contents ROM[i] = i[7:0], read latency 1 and 3
  logic [AW-1:0] ra1 = '0, ra3a = '0, ra3b = '0, ra3c = '0;
  always @(posedge clk) begin
    ra1  <= addr_in;
    ra3a <= addr_in3;
    ra3b <= ra3a;
    ra3c <= ra3b;
  end
  assign din  = ra1[7:0];
  assign din3 = ra3c[7:0];

  // RAM models tag every written word with the current job number
  int gen = 0;
  logic [DW-1:0] ram1 [1024];
  logic [DW-1:0] ram3 [1024];
  int wgen1 [1024];
  int wgen3 [1024];
  always @(posedge clk) begin
    if (we) begin ram1[addr_out] <= dout; wgen1[addr_out] <= gen; end
    if (we3) begin ram3[addr_out3] <= dout3; wgen3[addr_out3] <= gen; end
  end

  int n_vec = 0;
  int n_bad = 0;
  int n_wr, first_we, last_we, busy_first, busy_last, done_cyc, rd_bad, wr_bad;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One copy on the RD_LAT=1 engine; optionally pulses a conflicting start at cycle inj
  task automatic do_copy(input int l, input int s, input int d, input int inj);
    int c;
    int k;
    n_wr = 0; first_we = -1; last_we = -1; busy_first = -1; busy_last = -1;
    done_cyc = -1; rd_bad = 0; wr_bad = 0;
    @(negedge clk);
    start = 1'b1; len = (AW+1)'(l); src_base = AW'(s); dst_base = AW'(d);
    c = 0; k = 0;
    while (done_cyc < 0 && c < 3000) begin
      @(negedge clk);
      c++;
      if (busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (c <= l && addr_in != AW'((s + c - 1) % 1024)) rd_bad++;
      if (we) begin
        if (first_we < 0) first_we = c;
        last_we = c;
        if (addr_out != AW'((d + k) % 1024) || dout != DW'((s + k) % 256)) wr_bad++;
        k++;
        n_wr++;
      end
      if (done) done_cyc = c;
      start = (c == inj);
      if (c == inj) begin
        len = 4; src_base = 50; dst_base = 0;
      end
    end
    start = 1'b0;
    if (done_cyc < 0) chk("done timeout", 0, 1);
  endtask

  vec_t vecs [6];

  initial begin
    int bad;
    int a;
    int c;
    int exp_csum;

    vecs[0] = '{16,   0,    100,  16,   2, 17,   1, 17,   18};
    vecs[1] = '{0,    5,    7,    0,   -1, -1,  -1, -1,   1};
    vecs[2] = '{8,    1020, 1022, 8,    2, 9,    1, 9,    10};
    vecs[3] = '{1,    3,    1023, 1,    2, 2,    1, 2,    3};
    vecs[4] = '{5,    1022, 1021, 5,    2, 6,    1, 6,    7};
    vecs[5] = '{1024, 0,    0,    1024, 2, 1025, 1, 1025, 1026};

    reset = 1'b0; start = 1'b0; start3 = 1'b0;
    len = '0; len3 = '0; src_base = '0; dst_base = '0; src3 = '0; dst3 = '0;
    repeat (3) @(negedge clk);
    chk("reset we/busy/done", {we, busy, done}, 0);
    chk("reset addr_in", addr_in, 0);
    chk("reset addr_out/dout", {addr_out, dout}, 0);
    chk("reset lat3 outputs", {we3, busy3, done3, addr_in3, addr_out3, dout3}, 0);
`ifdef MEMCOPY_CHECKSUM_EN
    chk("reset csum", csum, 0);
`endif
    reset = 1'b1;
    @(negedge clk);
    chk("idle after reset", {we, busy, done}, 0);

    // Table-driven copies
    for (int v = 0; v < 6; v++) begin
      gen++;
      do_copy(vecs[v].len, vecs[v].src, vecs[v].dst, 0);
      chk($sformatf("v%0d writes", v), n_wr, vecs[v].writes);
      chk($sformatf("v%0d first_we", v), first_we, vecs[v].first_we);
      chk($sformatf("v%0d last_we", v), last_we, vecs[v].last_we);
      chk($sformatf("v%0d busy_first", v), busy_first, vecs[v].busy_first);
      chk($sformatf("v%0d busy_last", v), busy_last, vecs[v].busy_last);
      chk($sformatf("v%0d done_cyc", v), done_cyc, vecs[v].done_cyc);
      chk($sformatf("v%0d rd_addr_seq", v), rd_bad, 0);
      chk($sformatf("v%0d wr_seq", v), wr_bad, 0);
      bad = 0;
      for (int k = 0; k < vecs[v].len; k++) begin
        a = (vecs[v].dst + k) % 1024;
        if (ram1[a] != DW'((vecs[v].src + k) % 256) || wgen1[a] != gen) bad++;
      end
      if (vecs[v].len > 0 && vecs[v].len < 1023) begin
        if (wgen1[(vecs[v].dst + 1023) % 1024] == gen) bad++;
        if (wgen1[(vecs[v].dst + vecs[v].len) % 1024] == gen) bad++;
      end
      chk($sformatf("v%0d ram", v), bad, 0);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d done sticky", v), {done, busy, we}, 3'b100);
    end

    // Start pulsed mid-copy is ignored
    gen++;
    do_copy(16, 0, 200, 5);
    chk("midstart writes", n_wr, 16);
    chk("midstart done_cyc", done_cyc, 18);
    chk("midstart wr_seq", wr_bad, 0);
    bad = 0;
    for (int k = 0; k < 4; k++) if (wgen1[k] == gen) bad++;
    chk("midstart ram0..3 untouched", bad, 0);

    // Reset in the middle of a len=32 copy
    gen++;
    @(negedge clk);
    start = 1'b1; len = 32; src_base = 0; dst_base = 300;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre-reset we", we, 1);
    reset = 1'b0;
    #1;
    chk("async reset we", we, 0);
    chk("async reset outs", {addr_in, addr_out, dout, busy, done}, 0);
    bad = 0;
    for (int k = 300; k < 304; k++) if (wgen1[k] != gen) bad++;
    if (wgen1[304] == gen) bad++;
    chk("reset partial ram", bad, 0);
    @(negedge clk);
    reset = 1'b1;
    gen++;
    do_copy(32, 0, 300, 0);
    chk("post-reset writes", n_wr, 32);
    chk("post-reset done_cyc", done_cyc, 34);
    chk("post-reset seq", rd_bad + wr_bad, 0);

    // RD_LAT=3 full-array copy
    gen++;
    @(negedge clk);
    start3 = 1'b1; len3 = 1024; src3 = 0; dst3 = 0;
    n_wr = 0; first_we = -1; last_we = -1; done_cyc = -1;
    c = 0;
    while (done_cyc < 0 && c < 3000) begin
      @(negedge clk);
      c++;
      start3 = 1'b0;
      if (we3) begin
        if (first_we < 0) first_we = c;
        last_we = c;
        n_wr++;
      end
      if (done3) done_cyc = c;
    end
    if (done_cyc < 0) chk("lat3 done timeout", 0, 1);
    chk("lat3 writes", n_wr, 1024);
    chk("lat3 first_we", first_we, 4);
    chk("lat3 last_we", last_we, 1027);
    chk("lat3 done_cyc", done_cyc, 1028);
    bad = 0;
    for (int k = 0; k < 1024; k++) if (ram3[k] != DW'(k % 256) || wgen3[k] != gen) bad++;
    chk("lat3 ram", bad, 0);
    exp_csum = 0;
    for (int k = 0; k < 1024; k++) exp_csum += k % 256;
    exp_csum = exp_csum % 65536;
`ifdef MEMCOPY_CHECKSUM_EN
    chk("lat3 csum", csum3, exp_csum);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
